// File: rtl/multi_range_pipe_counter_if.sv
// Control/result bundle for multi_range_pipe_counter.
// The master drives the counter controls; the slave (the counter) drives the channel outputs.
interface multi_range_pipe_counter_if #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned NCH   = 2
);
  logic                   en;
  logic                   dir;
  logic                   clr;
  logic                   load;
  logic [WIDTH-1:0]       load_val;
  logic [NCH*WIDTH-1:0]   cnt_o;
  logic                   wrap_o;
  logic                   valid_o;

  modport master (
    output en, dir, clr, load, load_val,
    input  cnt_o, wrap_o, valid_o
  );

  modport slave (
    input  en, dir, clr, load, load_val,
    output cnt_o, wrap_o, valid_o
  );
endinterface

// File: rtl/multi_range_pipe_counter.sv
// Base modulo-MOD up/down counter fanned out to NCH channels offset by k*MOD,
// delayed DEPTH cycles with an aligned wrap pulse and a pipeline-valid flag.
module multi_range_pipe_counter #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned MOD   = 50,
  parameter int unsigned NCH   = 2,
  parameter int unsigned DEPTH = 2
) (
  input logic                      clk,
  input logic                      rst,
  multi_range_pipe_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] b_q, b_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic             wrp_q  [DEPTH];
  logic [DEPTH:0]   vld_q;

  // Priority: clr > load > en > hold. Only an enabled wrap raises the flag.
  always_comb begin
    b_d    = b_q;
    wrap_d = 1'b0;
    if (bus.clr) begin
      b_d = '0;
    end else if (bus.load) begin
      b_d = (bus.load_val > MaxVal) ? MaxVal : bus.load_val;
    end else if (bus.en) begin
      if (!bus.dir) begin
        if (b_q == MaxVal) begin
          b_d    = '0;
          wrap_d = 1'b1;
        end else begin
          b_d = b_q + WIDTH'(1);
        end
      end else begin
        if (b_q == '0) begin
          b_d    = MaxVal;
          wrap_d = 1'b1;
        end else begin
          b_d = b_q - WIDTH'(1);
        end
      end
    end
  end

  // The delay line runs every cycle regardless of en; vld_q has one extra stage
  // because the first valid base value appears one edge after reset releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_q    <= '0;
      wrap_q <= 1'b0;
      vld_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
        wrp_q[i]  <= 1'b0;
      end
    end else begin
      b_q       <= b_d;
      wrap_q    <= wrap_d;
      vld_q     <= {vld_q[DEPTH-1:0], 1'b1};
      pipe_q[0] <= b_q;
      wrp_q[0]  <= wrap_q;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
        wrp_q[i]  <= wrp_q[i-1];
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign bus.cnt_o[k*WIDTH +: WIDTH] = pipe_q[DEPTH-1] + WIDTH'(k * MOD);
  end

  assign bus.wrap_o  = wrp_q[DEPTH-1];
  assign bus.valid_o = vld_q[DEPTH];

endmodule
